// File: rtl/uart_tx_arbiter_if.sv
// Byte-source handshake and uart_tx drive bundle for uart_tx_arbiter.
// master = producer/test side, slave = the arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic                   tx_en;
   logic [NUM_REQ-1:0]     req_valid;
   logic [8*NUM_REQ-1:0]   req_data;
   logic [NUM_REQ-1:0]     req_ready;
   logic                   tx_start;
   logic [7:0]             tx_data;
   logic                   busy;
   logic [2:0]             grant_id;
   logic                   frame_done;

   modport master (
      output tx_en, req_valid, req_data,
      input  req_ready, tx_start, tx_data, busy, grant_id, frame_done
   );

   modport slave (
      input  tx_en, req_valid, req_data,
      output req_ready, tx_start, tx_data, busy, grant_id, frame_done
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among up to 8 byte sources.
// The transmitter has no busy output, so the frame length is timed here:
// one START cycle plus FRAME_CLKS-1 SEND cycles, then one IDLE cycle.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BAUD_CNT_MAX = 5207
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_arbiter_if.slave   io_bus
);
   localparam int                  FRAME_CLKS = 10 * (BAUD_CNT_MAX + 1);
   localparam int                  TIMER_W    = $clog2(FRAME_CLKS);
   localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(FRAME_CLKS - 2);
   localparam logic [TIMER_W-1:0]  TIMER_ONE  = TIMER_W'(1);
   localparam logic [3:0]          NUM_REQ_4  = 4'(NUM_REQ);
   localparam logic [2:0]          LAST_REQ   = 3'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_SEND  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [TIMER_W-1:0]   r_timer;
   logic [2:0]           r_rr_ptr;
   logic [7:0]           r_tx_data;
   logic                 r_busy;
   logic                 r_tx_start;
   logic                 r_frame_done;

   logic [7:0]           w_valid8;
   logic [63:0]          w_data64;
   logic                 w_found;
   logic [2:0]           w_winner;
   logic                 w_accept;
   logic [NUM_REQ-1:0]   w_ready;
   logic                 w_timer_zero;

   // Widen the request bus to the 8-source maximum so 3-bit indices select exactly.
   assign w_valid8     = 8'(io_bus.req_valid);
   assign w_data64     = 64'(io_bus.req_data);
   assign w_timer_zero = (r_timer == '0);

   // Round-robin search from rr_ptr+1; walking backwards lets the nearest candidate win.
   always_comb begin : p_rr_search
      logic [3:0] w_sum;
      logic [2:0] w_idx;
      w_sum    = 4'd0;
      w_idx    = 3'd0;
      w_found  = 1'b0;
      w_winner = 3'd0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_sum    = {1'b0, r_rr_ptr} + 4'(k);
         w_idx    = (w_sum >= NUM_REQ_4) ? 3'(w_sum - NUM_REQ_4) : w_sum[2:0];
         w_winner = w_valid8[w_idx] ? w_idx : w_winner;
         w_found  = w_found | w_valid8[w_idx];
      end
   end

   // One-hot ready to the winner, only in IDLE, enabled and out of reset.
   always_comb begin
      w_accept = 1'b0;
      w_ready  = '0;
      if (rst_n && (r_state == S_IDLE) && io_bus.tx_en && w_found) begin
         w_accept = 1'b1;
         w_ready  = NUM_REQ'(1) << w_winner;
      end else begin
         w_accept = 1'b0;
         w_ready  = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: IDLE -> START on acceptance, START -> SEND, SEND -> IDLE at timer end.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_START;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_START: begin
            w_state_nxt = S_SEND;
         end
         S_SEND: begin
            if (w_timer_zero) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_SEND;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Byte latch, pointer, frame timer and registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer      <= '0;
         r_rr_ptr     <= LAST_REQ;
         r_tx_data    <= 8'h00;
         r_busy       <= 1'b0;
         r_tx_start   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_tx_start   <= w_accept;
         r_frame_done <= (r_state == S_SEND) && (r_timer == TIMER_ONE);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tx_data <= w_data64[{w_winner, 3'b000} +: 8];
                  r_rr_ptr  <= w_winner;
                  r_busy    <= 1'b1;
               end
            end
            S_START: begin
               r_timer <= TIMER_LOAD;
            end
            S_SEND: begin
               if (w_timer_zero) begin
                  r_busy <= 1'b0;
               end else begin
                  r_timer <= r_timer - TIMER_ONE;
               end
            end
            default: begin
               r_timer <= '0;
            end
         endcase
      end
   end

   assign io_bus.req_ready  = w_ready;
   assign io_bus.tx_start   = r_tx_start;
   assign io_bus.tx_data    = r_tx_data;
   assign io_bus.busy       = r_busy;
   assign io_bus.grant_id   = r_rrptr_out();
   assign io_bus.frame_done = r_frame_done;

   // The round-robin pointer doubles as the last-granted index.
   function automatic logic [2:0] r_rrptr_out();
      return r_rr_ptr;
   endfunction
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a small uart_tx line model.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ = 4;
   localparam int BAUD    = 9;
   localparam int FRAME   = 10 * (BAUD + 1);

   typedef struct packed {
      logic       en;
      logic [3:0] valid;
      logic [3:0] exp_ready;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   vec_t tbl [10];

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BAUD_CNT_MAX(BAUD)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   // uart_tx line model: start bit, 8 data bits LSB first, stop bit, BAUD+1 clocks each.
   logic       tx_line;
   logic [9:0] sh;
   logic [3:0] nbit;
   int         baud;
   logic       run;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_line <= 1'b1; sh <= '1; nbit <= 4'd0; baud <= 0; run <= 1'b0;
      end else if (bus.tx_start) begin
         sh <= {1'b1, bus.tx_data, 1'b0}; nbit <= 4'd0; baud <= 0; run <= 1'b1; tx_line <= 1'b0;
      end else if (run) begin
         if (baud == BAUD) begin
            baud <= 0;
            if (nbit == 4'd9) begin
               run <= 1'b0; tx_line <= 1'b1;
            end else begin
               nbit <= nbit + 4'd1; tx_line <= sh[nbit + 4'd1];
            end
         end else begin
            baud <= baud + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference round-robin choice: first valid index after rr, wrapping.
   function automatic int pick(input int rr, input logic [3:0] v);
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = (rr + k) % NUM_REQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic int oh2idx(input logic [3:0] oh);
      for (int i = 0; i < NUM_REQ; i++) if (oh[i]) return i;
      return -1;
   endfunction

   task automatic do_reset();
      bus.tx_en = 1'b1; bus.req_valid = '0; bus.req_data = '0;
      @(negedge clk); rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge clk); #1;
         if (bus.busy === 1'b0) break;
      end
      chk(name, 32'(k < 300), 32'd1);
   endtask

   task automatic stream(input logic [3:0] v, input int nfr, input int eg [5], input string name);
      int last_t, got;
      last_t = -1; got = 0;
      bus.req_valid = v;
      for (int t = 0; t < nfr * (FRAME + 1) + 20 && got < nfr; t++) begin
         @(negedge clk); #1;
         if (bus.tx_start === 1'b1) begin
            chk({name, "_grant"}, 32'(bus.grant_id), 32'(eg[got]));
            chk({name, "_data"}, 32'(bus.tx_data), 32'(bus.req_data[8*eg[got] +: 8]));
            if (got > 0) chk({name, "_spacing"}, 32'(t - last_t), 32'(FRAME + 1));
            last_t = t; got++;
         end
      end
      chk({name, "_count"}, 32'(got), 32'(nfr));
      bus.req_valid = '0;
      wait_idle({name, "_idle"});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic       txs [1:105];
      logic [7:0] rx;
      int         fd_at, fd_n, st_n, hi, k, bad, w;
      logic [3:0] pend, exp_rdy;
      logic [7:0] pb [4];
      int         rr, last, eg;
      logic [7:0] eb;
      logic       en;

      tbl[0] = '{1'b1, 4'b0001, 4'b0001};
      tbl[1] = '{1'b1, 4'b1111, 4'b0010};
      tbl[2] = '{1'b1, 4'b1001, 4'b1000};
      tbl[3] = '{1'b0, 4'b1111, 4'b0000};
      tbl[4] = '{1'b1, 4'b0110, 4'b0010};
      tbl[5] = '{1'b1, 4'b0010, 4'b0010};
      tbl[6] = '{1'b1, 4'b0000, 4'b0000};
      tbl[7] = '{1'b1, 4'b0101, 4'b0100};
      tbl[8] = '{1'b1, 4'b0011, 4'b0001};
      tbl[9] = '{1'b1, 4'b1000, 4'b1000};

      bus.tx_en = 1'b0; bus.req_valid = '0; bus.req_data = '0;
      do_reset();
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_start", 32'(bus.tx_start), 32'd0);
      chk("rst_data", 32'(bus.tx_data), 32'h00);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_grant", 32'(bus.grant_id), 32'(NUM_REQ - 1));
      chk("rst_done", 32'(bus.frame_done), 32'd0);
      chk("rst_tx", 32'(tx_line), 32'd1);

      // Table-driven arbitration vectors (pointer starts at NUM_REQ-1).
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.tx_en = tbl[i].en; bus.req_valid = tbl[i].valid;
         for (int r = 0; r < NUM_REQ; r++) bus.req_data[8*r +: 8] = 8'((i << 4) | r);
         #1 chk("tbl_ready", 32'(bus.req_ready), 32'(tbl[i].exp_ready));
         w = oh2idx(tbl[i].exp_ready);
         @(posedge clk); #1 bus.req_valid = '0;
         @(negedge clk); #1;
         if (w >= 0) begin
            chk("tbl_start", 32'(bus.tx_start), 32'd1);
            chk("tbl_grant", 32'(bus.grant_id), 32'(w));
            chk("tbl_data", 32'(bus.tx_data), 32'((i << 4) | w));
            chk("tbl_busy", 32'(bus.busy), 32'd1);
            chk("tbl_ready_off", 32'(bus.req_ready), 32'd0);
            wait_idle("tbl_idle");
         end else begin
            chk("tbl_nostart", 32'(bus.tx_start), 32'd0);
            chk("tbl_nobusy", 32'(bus.busy), 32'd0);
         end
      end

      // Single frame, serial decode and frame_done timing.
      do_reset();
      @(negedge clk);
      bus.req_data = 32'h000000A5; bus.req_valid = 4'b0001;
      #1 chk("f1_ready", 32'(bus.req_ready), 32'b0001);
      @(posedge clk); #1 bus.req_valid = '0;
      @(negedge clk); #1;
      chk("f1_start", 32'(bus.tx_start), 32'd1);
      chk("f1_ready_off", 32'(bus.req_ready), 32'd0);
      fd_at = -1; fd_n = 0; st_n = 0;
      for (int t = 1; t <= 105; t++) begin
         @(negedge clk); #1;
         txs[t] = tx_line;
         if (bus.frame_done === 1'b1) begin fd_n++; if (fd_at < 0) fd_at = t; end
         if (bus.tx_start === 1'b1) st_n++;
      end
      for (int j = 0; j < 8; j++) rx[j] = txs[16 + 10*j];
      hi = 0;
      for (int t = 91; t <= 100; t++) if (txs[t]) hi++;
      chk("f1_startbit", 32'(txs[6]), 32'd0);
      chk("f1_byte", 32'(rx), 32'hA5);
      chk("f1_stop_len", 32'(hi), 32'd10);
      chk("f1_done_at", 32'(fd_at), 32'd99);
      chk("f1_done_once", 32'(fd_n), 32'd1);
      chk("f1_one_start", 32'(st_n), 32'd0);
      chk("f1_idle", 32'(bus.busy), 32'd0);

      // All four requesting: strict rotation, FRAME+1 spacing.
      do_reset();
      bus.req_data = 32'h13121110;
      stream(4'b1111, 5, '{0, 1, 2, 3, 0}, "rr4");

      // Lone requester re-granted every frame.
      do_reset();
      bus.req_data = 32'h005C0000;
      stream(4'b0100, 3, '{2, 2, 2, 0, 0}, "self");

      // tx_en gating, then tx_en dropped mid-SEND.
      do_reset();
      @(negedge clk);
      bus.tx_en = 1'b0; bus.req_data = 32'h00004D00; bus.req_valid = 4'b0010;
      bad = 0;
      for (int t = 0; t < 500; t++) begin
         #1 if (bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("en_off_quiet", 32'(bad), 32'd0);
      bus.tx_en = 1'b1;
      #1 chk("en_on_ready", 32'(bus.req_ready), 32'b0010);
      @(posedge clk); #1 bus.req_valid = '0;
      @(negedge clk); #1;
      chk("en_on_start", 32'(bus.tx_start), 32'd1);
      chk("en_on_grant", 32'(bus.grant_id), 32'd1);
      chk("en_on_data", 32'(bus.tx_data), 32'h4D);
      repeat (30) @(negedge clk);
      bus.tx_en = 1'b0; bus.req_valid = 4'b0010;
      #1;
      for (k = 0; k < 200; k++) begin
         if (bus.frame_done === 1'b1) break;
         @(negedge clk); #1;
      end
      chk("en_drop_done", 32'(k), 32'd69);
      bad = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk); #1;
         if (bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0) bad++;
      end
      chk("en_drop_quiet", 32'(bad), 32'd0);
      bus.req_valid = '0; bus.tx_en = 1'b1;

      // Reset 40 clocks into a frame.
      do_reset();
      @(negedge clk);
      bus.req_data = 32'h00C3003C; bus.req_valid = 4'b0101;
      #1 chk("mr_ready", 32'(bus.req_ready), 32'b0001);
      @(negedge clk); #1;
      chk("mr_start", 32'(bus.tx_start), 32'd1);
      chk("mr_data", 32'(bus.tx_data), 32'h3C);
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mr_rst_ready", 32'(bus.req_ready), 32'd0);
      chk("mr_rst_start", 32'(bus.tx_start), 32'd0);
      chk("mr_rst_data", 32'(bus.tx_data), 32'h00);
      chk("mr_rst_busy", 32'(bus.busy), 32'd0);
      chk("mr_rst_grant", 32'(bus.grant_id), 32'(NUM_REQ - 1));
      chk("mr_rst_done", 32'(bus.frame_done), 32'd0);
      chk("mr_rst_tx", 32'(tx_line), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("mr_regrant", 32'(bus.req_ready), 32'b0001);
      @(posedge clk); #1 bus.req_valid = '0;
      @(negedge clk); #1;
      chk("mr_restart", 32'(bus.tx_start), 32'd1);
      chk("mr_regrant_id", 32'(bus.grant_id), 32'd0);
      wait_idle("mr_idle");

      // Request raised during SEND waits for the first IDLE cycle.
      do_reset();
      @(negedge clk);
      bus.req_data = 32'h00007E81; bus.req_valid = 4'b0001;
      @(posedge clk); #1 bus.req_valid = '0;
      @(negedge clk); #1 chk("late_start", 32'(bus.tx_start), 32'd1);
      repeat (20) @(negedge clk);
      bus.req_valid = 4'b0010;
      #1;
      for (k = 0; k < 200; k++) begin
         if (bus.req_ready !== 4'b0000) break;
         @(negedge clk); #1;
      end
      chk("late_wait", 32'(k), 32'd80);
      chk("late_ready", 32'(bus.req_ready), 32'b0010);
      chk("late_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1 bus.req_valid = '0;
      wait_idle("late_idle");

      // Randomized traffic against a cycle-count reference model.
      do_reset();
      pend = '0; rr = NUM_REQ - 1; last = -1000; eg = 0; eb = 8'h00; en = 1'b1;
      for (int i = 0; i < 4; i++) pb[i] = 8'h00;
      for (int n = 0; n < 6000; n++) begin
         @(negedge clk);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i]) begin
               if ($urandom_range(0, 99) < 4) begin pend[i] = 1'b1; pb[i] = 8'($urandom); end
            end else if ($urandom_range(0, 199) == 0) begin
               pend[i] = 1'b0;
            end
         end
         if ($urandom_range(0, 299) == 0) en = !en;
         bus.tx_en = en; bus.req_valid = pend;
         for (int i = 0; i < NUM_REQ; i++) bus.req_data[8*i +: 8] = pb[i];
         #1;
         exp_rdy = 4'b0000;
         if (n >= last + FRAME + 1 && en && pend != 4'b0000) exp_rdy = 4'b0001 << pick(rr, pend);
         chk("rnd_ready", 32'(bus.req_ready), 32'(exp_rdy));
         chk("rnd_start", 32'(bus.tx_start), 32'(n == last + 1));
         chk("rnd_done", 32'(bus.frame_done), 32'(n == last + FRAME));
         chk("rnd_busy", 32'(bus.busy), 32'(n > last && n <= last + FRAME));
         if (n == last + 1) begin
            chk("rnd_data", 32'(bus.tx_data), 32'(eb));
            chk("rnd_grant", 32'(bus.grant_id), 32'(eg));
         end
         if (exp_rdy != 4'b0000) begin
            w = pick(rr, pend);
            last = n; rr = w; eg = w; eb = pb[w]; pend[w] = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
